gb_cpu_interrupt_ctrl: RTL and testbench

Interrupt controller for the Game Boy CPU core. It owns the IME flag, applies the delayed effect of EI, enters and leaves HALT, and decides at each instruction boundary whether the next opcode fetch is replaced by a 5 M-cycle interrupt dispatch. It sits upstream of the scheduler and decoder: `int_dispatch` makes the decoder emit the dispatch schedule instead of the fetched opcode. It also supplies the jump vector and the IF-clear strobe to the datapath.

---
 rtl/gb_cpu_common_pkg.sv | 19 +
 rtl/gb_cpu_interrupt_ctrl_if.sv | 31 +++
 rtl/gb_cpu_int_priority.sv | 20 ++
 rtl/gb_cpu_interrupt_ctrl.sv | 136 +++++++++++++
 tb/tb_gb_cpu_interrupt_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared types and constants for the Game Boy CPU core
package gb_cpu_common_pkg;

  // Interrupt controller top-level modes
  typedef enum logic [1:0] {
    INT_RUN,
    INT_HALT,
    INT_DISPATCH
  } int_state_t;

  localparam int          INT_DISPATCH_CYCLES = 5;
  localparam logic [7:0]  INT_VECTOR_BASE     = 8'h40;

  // One-hot mask for an interrupt index (0 = VBlank .. 4 = Joypad)
  function automatic logic [4:0] int_onehot(input logic [2:0] idx);
    return 5'b00001 << idx;
  endfunction

endpackage

// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// rtl/gb_cpu_interrupt_ctrl_if.sv - signal bundle between CPU core and interrupt controller
interface gb_cpu_interrupt_ctrl_if;

  logic [2:0] curr_m_cycle;
  logic       enable_interrupts;
  logic       disable_interrupts;
  logic       reti;
  logic       halt_req;
  logic [4:0] ie_reg;
  logic [4:0] if_reg;

  logic       int_dispatch;
  logic       dispatching;
  logic [7:0] int_vector;
  logic [4:0] if_clear;
  logic       ime;
  logic       halted;

  // Core side: drives scheduler/control strobes, consumes dispatch control
  modport master (
    output curr_m_cycle, enable_interrupts, disable_interrupts, reti, halt_req, ie_reg, if_reg,
    input  int_dispatch, dispatching, int_vector, if_clear, ime, halted
  );

  // Controller side
  modport slave (
    input  curr_m_cycle, enable_interrupts, disable_interrupts, reti, halt_req, ie_reg, if_reg,
    output int_dispatch, dispatching, int_vector, if_clear, ime, halted
  );

endinterface

// File: rtl/gb_cpu_int_priority.sv
// rtl/gb_cpu_int_priority.sv - lowest-set-bit encoder for the five interrupt sources
module gb_cpu_int_priority (
  input  logic [4:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan from the top down so the lowest-numbered request is the last to write
  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// rtl/gb_cpu_interrupt_ctrl.sv - IME/EI/HALT handling and interrupt dispatch sequencing
module gb_cpu_interrupt_ctrl
  import gb_cpu_common_pkg::*;
#(
  parameter int         DISPATCH_CYCLES = INT_DISPATCH_CYCLES,
  parameter logic [7:0] VECTOR_BASE     = INT_VECTOR_BASE
) (
  input  logic                    clk,
  input  logic                    reset,
  gb_cpu_interrupt_ctrl_if.slave  bus
);

  localparam logic [2:0] LATCH_CYCLE = 3'd3;
  localparam logic [2:0] CLEAR_CYCLE = 3'd4;
  localparam logic [2:0] LAST_CYCLE  = 3'(DISPATCH_CYCLES);

  int_state_t state_q, state_d;
  logic [2:0] cnt_q;
  logic       ime_q;
  logic       ei_pending_q;
  logic [7:0] vector_q;
  logic [2:0] idx_q;
  logic       idx_valid_q;

  logic [4:0] req;
  logic       pending;
  logic       boundary;
  logic       dispatch_start;
  logic [2:0] prio_idx;
  logic       prio_valid;

  assign req      = bus.ie_reg & bus.if_reg;
  assign pending  = |req;
  assign boundary = (bus.curr_m_cycle == 3'd0);

  gb_cpu_int_priority u_priority (
    .req   (req),
    .idx   (prio_idx),
    .valid (prio_valid)
  );

  // Mode register
  always_ff @(posedge clk) begin
    if (reset) state_q <= INT_RUN;
    else       state_q <= state_d;
  end

  // Next mode; dispatch_start is the combinational boundary decision
  always_comb begin
    state_d        = state_q;
    dispatch_start = 1'b0;
    case (state_q)
      INT_RUN: begin
        if (boundary && ime_q && pending) begin
          state_d        = INT_DISPATCH;
          dispatch_start = 1'b1;
        end else if (bus.halt_req) begin
          state_d = INT_HALT;
        end
      end
      INT_HALT: begin
        if (pending) begin
          if (ime_q) begin
            state_d        = INT_DISPATCH;
            dispatch_start = 1'b1;
          end else begin
            state_d = INT_RUN;
          end
        end
      end
      INT_DISPATCH: begin
        if (cnt_q == LAST_CYCLE) state_d = INT_RUN;
      end
      default: state_d = INT_RUN;
    endcase
  end

  // Dispatch M-cycle counter, 1..DISPATCH_CYCLES while dispatching, else 0
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else if (dispatch_start) begin
      cnt_q <= 3'd1;
    end else if (state_q == INT_DISPATCH) begin
      cnt_q <= (cnt_q == LAST_CYCLE) ? 3'd0 : cnt_q + 3'd1;
    end
  end

  // IME and delayed-EI tracking; later assignments take precedence (DI beats EI/RETI, dispatch beats all)
  always_ff @(posedge clk) begin
    if (reset) begin
      ime_q        <= 1'b0;
      ei_pending_q <= 1'b0;
    end else if (state_q != INT_DISPATCH) begin
      if (boundary && ei_pending_q) begin
        ime_q        <= 1'b1;
        ei_pending_q <= 1'b0;
      end
      if (bus.enable_interrupts) ei_pending_q <= 1'b1;
      if (bus.reti) begin
        ime_q        <= 1'b1;
        ei_pending_q <= 1'b0;
      end
      if (bus.disable_interrupts) begin
        ime_q        <= 1'b0;
        ei_pending_q <= 1'b0;
      end
      if (dispatch_start) begin
        ime_q        <= 1'b0;
        ei_pending_q <= 1'b0;
      end
    end
  end

  // Priority is resolved late so a request withdrawn before the PC-high push cancels the dispatch
  always_ff @(posedge clk) begin
    if (reset) begin
      vector_q    <= 8'h00;
      idx_q       <= 3'd0;
      idx_valid_q <= 1'b0;
    end else if (state_q == INT_DISPATCH && cnt_q == LATCH_CYCLE) begin
      idx_q       <= prio_idx;
      idx_valid_q <= prio_valid;
      vector_q    <= prio_valid ? (VECTOR_BASE + {2'b00, prio_idx, 3'b000}) : 8'h00;
    end
  end

  assign bus.int_dispatch = dispatch_start;
  assign bus.dispatching  = (state_q == INT_DISPATCH);
  assign bus.halted       = (state_q == INT_HALT);
  assign bus.int_vector   = vector_q;
  assign bus.ime          = ime_q;
  assign bus.if_clear     = (state_q == INT_DISPATCH && cnt_q == CLEAR_CYCLE && idx_valid_q)
                            ? int_onehot(idx_q) : 5'd0;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// tb/tb_gb_cpu_interrupt_ctrl.sv - randomized self-checking bench for gb_cpu_interrupt_ctrl
module tb_gb_cpu_interrupt_ctrl;

  logic clk = 1'b0;
  logic reset;

  gb_cpu_interrupt_ctrl_if bus();

  gb_cpu_interrupt_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: dispatch progress as a plain cycle number (0 = none)
  bit       m_ime;
  bit       m_eip;
  bit       m_halt;
  int       m_cnt;
  bit [7:0] m_vec;
  bit [4:0] m_clr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_ime = 0; m_eip = 0; m_halt = 0; m_cnt = 0; m_vec = 8'h00; m_clr = 5'd0;
  endtask

  task automatic step(input bit r, input bit [2:0] m, input bit e, input bit d, input bit rt,
                      input bit h, input bit [4:0] ie, input bit [4:0] ifr);
    bit pend, bnd, start, found;
    @(negedge clk);
    reset = r;
    bus.curr_m_cycle = m;  bus.enable_interrupts = e; bus.disable_interrupts = d;
    bus.reti = rt;         bus.halt_req = h;          bus.ie_reg = ie; bus.if_reg = ifr;
    #1;
    pend  = |(ie & ifr);
    bnd   = (m == 3'd0);
    start = (m_cnt == 0) && pend && m_ime && (m_halt || bnd);
    check_val("int_dispatch", bus.int_dispatch, start);
    check_val("dispatching",  bus.dispatching,  m_cnt != 0);
    check_val("halted",       bus.halted,       m_halt);
    check_val("ime",          bus.ime,          m_ime);
    check_val("int_vector",   bus.int_vector,   m_vec);
    check_val("if_clear",     bus.if_clear,     (m_cnt == 4) ? m_clr : 5'd0);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_cnt != 0) begin
      if (m_cnt == 3) begin
        found = 0; m_vec = 8'h00; m_clr = 5'd0;
        for (int i = 0; i < 5; i++)
          if (!found && ie[i] && ifr[i]) begin
            found = 1; m_vec = 8'h40 + 8'(8 * i); m_clr = 5'(1 << i);
          end
      end
      m_cnt = (m_cnt == 5) ? 0 : m_cnt + 1;
    end else begin
      if (bnd && m_eip) begin m_ime = 1; m_eip = 0; end
      if (e)  m_eip = 1;
      if (rt) begin m_ime = 1; m_eip = 0; end
      if (d)  begin m_ime = 0; m_eip = 0; end
      if (start) begin
        m_ime = 0; m_eip = 0; m_cnt = 1; m_halt = 0;
      end else if (m_halt && pend) begin
        m_halt = 0;
      end else if (!m_halt && h) begin
        m_halt = 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.curr_m_cycle = 3'd1; bus.enable_interrupts = 0; bus.disable_interrupts = 0;
    bus.reti = 0; bus.halt_req = 0; bus.ie_reg = 5'd0; bus.if_reg = 5'd0;
    repeat (2) @(posedge clk);
    model_reset();
    step(0, 3'd1, 0, 0, 0, 0, 5'd0, 5'd0);

    // Single VBlank dispatch
    step(0, 3'd1, 0, 0, 1, 0, 5'h00, 5'h00);
    step(0, 3'd0, 0, 0, 0, 0, 5'h01, 5'h01);
    for (int c = 1; c <= 3; c++) step(0, 3'(c), 0, 0, 0, 0, 5'h01, 5'h01);
    #1;
    check_val("vb_if_clear", bus.if_clear, 5'h01);
    check_val("vb_vector", bus.int_vector, 8'h40);
    check_val("vb_ime", bus.ime, 1'b0);
    step(0, 3'd4, 0, 0, 0, 0, 5'h01, 5'h00);
    step(0, 3'd5, 0, 0, 0, 0, 5'h01, 5'h00);

    // EI then NOP: dispatch only at the second boundary
    step(0, 3'd0, 1, 0, 0, 0, 5'h04, 5'h04);
    #1; check_val("ei_nop_no_disp", bus.int_dispatch, 1'b0);
    step(0, 3'd0, 0, 0, 0, 0, 5'h04, 5'h04);
    #1; check_val("ei_second_disp", bus.int_dispatch, 1'b1);
    for (int c = 0; c <= 3; c++) step(0, 3'(c), 0, 0, 0, 0, 5'h04, 5'h04);
    #1; check_val("ei_vector", bus.int_vector, 8'h50);
    step(0, 3'd4, 0, 0, 0, 0, 5'h04, 5'h00);
    step(0, 3'd5, 0, 0, 0, 0, 5'h04, 5'h00);

    // EI and DI together: DI wins
    step(0, 3'd0, 1, 1, 0, 0, 5'h01, 5'h01);
    for (int b = 0; b < 4; b++) begin
      step(0, 3'd0, 0, 0, 0, 0, 5'h01, 5'h01);
      #1;
      check_val("eidi_no_disp", bus.int_dispatch, 1'b0);
      check_val("eidi_ime", bus.ime, 1'b0);
    end

    // HALT with IME=0 wakes without dispatch
    step(0, 3'd1, 0, 0, 0, 1, 5'h10, 5'h00);
    #1; check_val("halt_enter", bus.halted, 1'b1);
    step(0, 3'd0, 0, 0, 0, 0, 5'h10, 5'h10);
    #1; check_val("halt_wake", bus.halted, 1'b0);
    for (int b = 0; b < 3; b++) begin
      step(0, 3'd0, 0, 0, 0, 0, 5'h10, 5'h10);
      #1;
      check_val("wake_no_disp", bus.dispatching, 1'b0);
      check_val("wake_no_clear", bus.if_clear, 5'h00);
    end

    // Cancelled dispatch, then a two-source dispatch
    step(0, 3'd1, 0, 0, 1, 0, 5'h00, 5'h00);
    step(0, 3'd0, 0, 0, 0, 0, 5'h02, 5'h02);
    step(0, 3'd1, 0, 0, 0, 0, 5'h02, 5'h02);
    step(0, 3'd2, 0, 0, 0, 0, 5'h02, 5'h00);
    step(0, 3'd3, 0, 0, 0, 0, 5'h02, 5'h00);
    #1;
    check_val("cancel_vector", bus.int_vector, 8'h00);
    check_val("cancel_clear", bus.if_clear, 5'h00);
    step(0, 3'd4, 0, 0, 0, 0, 5'h02, 5'h00);
    step(0, 3'd5, 0, 0, 0, 0, 5'h02, 5'h00);
    step(0, 3'd1, 0, 0, 1, 0, 5'h00, 5'h00);
    for (int c = 0; c <= 3; c++) step(0, 3'(c), 0, 0, 0, 0, 5'h06, 5'h06);
    #1;
    check_val("two_src_vector", bus.int_vector, 8'h48);
    check_val("two_src_clear", bus.if_clear, 5'h02);
    step(0, 3'd4, 0, 0, 0, 0, 5'h06, 5'h04);
    step(0, 3'd5, 0, 0, 0, 0, 5'h06, 5'h04);

    // Reset in dispatch cycle 2
    step(0, 3'd1, 0, 0, 1, 0, 5'h00, 5'h00);
    step(0, 3'd0, 0, 0, 0, 0, 5'h08, 5'h08);
    step(0, 3'd1, 0, 0, 0, 0, 5'h08, 5'h08);
    step(1, 3'd2, 0, 0, 0, 0, 5'h08, 5'h08);
    #1;
    check_val("rst_dispatching", bus.dispatching, 1'b0);
    check_val("rst_ime", bus.ime, 1'b0);
    check_val("rst_vector", bus.int_vector, 8'h00);
    check_val("rst_clear", bus.if_clear, 5'h00);
    check_val("rst_halted", bus.halted, 1'b0);
    check_val("rst_int_dispatch", bus.int_dispatch, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      bit [2:0] m;
      bit [4:0] ifr;
      m   = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 5));
      ifr = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      step($urandom_range(0, 99) == 0, m,
           $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
           5'($urandom), ifr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
